// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of JK flip-flops with enable, synchronous clear,
// parallel load and a JK-chained up/down counter mode with terminal-count pulse.
// All outputs (q, changed, tc) are registered; there is no input-to-output
// combinational path.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] changed,
    output logic             tc
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] changed_r;
    logic             tc_r;

    logic [WIDTH-1:0] q_next_s;
    logic             tc_next_s;

    // Single-bit JK characteristic: hold / reset / set / toggle.
    function automatic logic jk_bit(input logic cur, input logic jb, input logic kb);
        logic nxt;
        case ({jb, kb})
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Chained toggle enables: bit i toggles when every lower bit equals
    // match_val (1 for counting up, 0 for counting down); bit 0 always toggles.
    function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] cur,
                                                     input logic             match_val);
        logic [WIDTH-1:0] mask;
        logic             run;
        mask = '0;
        run  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = run;
            run     = run & (cur[i] == match_val);
        end
        return mask;
    endfunction

    // Next-state and terminal-count decode for an enabled, non-cleared edge.
    always_comb begin
        q_next_s  = q_r;
        tc_next_s = 1'b0;
        case (mode)
            MODE_JK: begin
                for (int i = 0; i < WIDTH; i++) begin
                    q_next_s[i] = jk_bit(q_r[i], j[i], k[i]);
                end
                tc_next_s = 1'b0;
            end
            MODE_LOAD: begin
                q_next_s  = d;
                tc_next_s = 1'b0;
            end
            MODE_UP: begin
                q_next_s  = q_r ^ toggle_mask(q_r, 1'b1);
                tc_next_s = &q_r;
            end
            MODE_DOWN: begin
                q_next_s  = q_r ^ toggle_mask(q_r, 1'b0);
                tc_next_s = ~|q_r;
            end
            default: begin
                q_next_s  = q_r;
                tc_next_s = 1'b0;
            end
        endcase
    end

    // State register with priority reset > clear > hold (en low) > mode update.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            q_r       <= RESET_VAL;
            changed_r <= '0;
            tc_r      <= 1'b0;
        end else if (clr) begin
            q_r       <= RESET_VAL;
            changed_r <= q_r ^ RESET_VAL;
            tc_r      <= 1'b0;
        end else if (!en) begin
            q_r       <= q_r;
            changed_r <= '0;
            tc_r      <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            changed_r <= q_next_s ^ q_r;
            tc_r      <= tc_next_s;
        end
    end

    assign q       = q_r;
    assign changed = changed_r;
    assign tc      = tc_r;

endmodule
